rca_dispatch_unit: RTL and testbench
====================================

# rca_dispatch_unit

Multi-accelerator successor to the single-RCA stub unit. It sits between the Taiga issue stage and the writeback arbiter and owns the source/destination register-address configuration for NUM_RCAS reconfigurable accelerators. It queues execute requests, dispatches them in order to idle RCAs, and returns one writeback completion per cycle. Config-write and execute completion paths are kept separate.

## Interface
Parameters:
- NUM_RCAS, 4, number of attached RCAs (≥1)
- NUM_SRC, 3, source-address ports per RCA
- NUM_DEST, 2, destination-address ports per RCA
- QUEUE_DEPTH, 4, execute-request FIFO entries (power of two, ≥2)
- ID_W, 3, instruction-id width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- issue_new_request  in  1  request accepted this cycle (only when issue_ready)
- issue_ready  out  1  unit can accept a request
- issue_instruction_id  in  ID_W  id of the request
- req_config  in  1  1 = config write, 0 = execute
- req_rca_sel  in  $clog2(NUM_RCAS)  target RCA
- req_w_src_dest  in  1  0 = source port, 1 = destination port
- req_w_port_sel  in  $clog2(max(NUM_SRC,NUM_DEST))  port index
- req_w_reg_addr  in  5  register address to store
- rca_src_reg_addrs  out  NUM_RCAS*NUM_SRC*5  config registers
- rca_dest_reg_addrs  out  NUM_RCAS*NUM_DEST*5  config registers
- rca_start  out  NUM_RCAS  one-cycle start pulse per RCA
- rca_start_id  out  ID_W  id accompanying rca_start
- rca_done  in  NUM_RCAS  one-cycle completion pulse per RCA
- wb_done  out  1  completion valid
- wb_id  out  ID_W  completing instruction id
- wb_rd  out  32  result data, tied to 0

## Operation
- Reset:
  - all config registers 0
  - FIFO empty
  - busy, pending and config-wb flags 0
  - rca_start, wb_done, wb_id all 0
  - issue_ready = 1 once rst deasserts
- issue_ready = !fifo_full. It does not depend on request type.
- Config write:
  - On accept, writes req_w_reg_addr into the selected RCA/port register.
  - Out-of-range port index is ignored, but the write still completes.
  - Sets the config-wb flag with the id.
  - Does not enter the FIFO.
- Execute:
  - On accept, pushes {id, rca_sel} into the FIFO.
- Dispatch, strictly in order:
  - If the FIFO is non-empty and busy[head.sel]==0: assert rca_start[head.sel] and rca_start_id=head.id, set busy, latch id, pop.
  - At most one dispatch per cycle.
  - Head-of-line blocking when the head's RCA is busy.
- Completion:
  - rca_done[i] with busy[i]=1 sets pending[i].
  - rca_done[i] with busy[i]=0, or with pending[i] already set, is ignored.
- Writeback, one per cycle:
  - Priority: config-wb flag first, then lowest-index pending RCA.
  - An RCA writeback clears pending[i] and busy[i] in the same cycle, so a re-dispatch to that RCA can occur the next cycle.
- Push and pop in the same cycle with a full FIFO: not possible, because ready is low while full.
- Push and pop in the same cycle otherwise: count unchanged.

## Timing
- Config accepted in cycle N:
  - register visible on outputs in N+1
  - wb_done=1 with that id in N+1
  - never stalled, since config-wb has top priority and at most one config arrives per cycle
- Execute accepted in N, FIFO empty, RCA idle: rca_start in N+1.
- rca_done sampled in M:
  - wb_done in M+1 when no config-wb competes in M+1
  - otherwise delayed one cycle per losing arbitration
- wb_done is a single-cycle pulse per completion.
- Pointers wrap modulo QUEUE_DEPTH. Full uses an extra count bit.
- Reset asserted mid-operation:
  - in-flight RCAs are dropped
  - their later rca_done is ignored, because busy=0

## Configuration
- RCA_PERF_CNT_EN:
  - Defined: adds output rca_exec_count, NUM_RCAS*32 bits. Per-RCA wrapping counter, incremented on each RCA writeback, reset 0.
  - Undefined: port and counters absent. All other behaviour is identical.

## Structure
- Package rca_types (shared):
  - RCA_REG_ADDR_W=5
  - rca_req_t {id, rca_sel}
  - rca_config_t holding the packed address arrays
- Sub-module rca_req_fifo: parametrised depth/width, push/pop/full/empty, async reset.
- Config registers, busy/pending tracking and the writeback arbiter stay in rca_dispatch_unit.

## Test plan
- Config write: RCA 2, dest port 1, addr 17, id 5 → rca_dest_reg_addrs slice [2][1]=17 next cycle; wb_done=1, wb_id=5 next cycle.
- Execute: ids 1,2 to RCA 0, back to back → start(id1) at N+1. Id2 holds until id1's writeback. rca_start[0] with id 2 the cycle after that writeback.
- Fill FIFO: 4 executes to a busy RCA → issue_ready=0 after the 4th. One pop → issue_ready=1 next cycle.
- Simultaneous completion: rca_done on RCA 1 and RCA 3 in the same cycle, plus a config accept → wb order config, RCA1, RCA3 on consecutive cycles.
- Reset mid-flight: assert rst with 2 RCAs busy, then pulse rca_done → no wb_done; outputs 0; config registers 0.
- With RCA_PERF_CNT_EN defined: 3 completions on RCA 0 → rca_exec_count[0]=3.

Source files
------------

// File: rtl/rca_types.sv
`default_nettype none
// ============================================================================
// Package  : rca_types
// Summary  : Shared constants, sizing helpers and request/config types for the
//            multi-RCA dispatch unit. The struct types describe the default
//            configuration (4 RCAs, 3 source / 2 destination ports, 3-bit id).
//            Modules parametrised away from that default size their storage
//            with the helpers below.
// Revision : 1.0 - initial release
// ============================================================================
package rca_types;

    localparam int RCA_REG_ADDR_W   = 5;

    localparam int RCA_DEF_NUM_RCAS = 4;
    localparam int RCA_DEF_NUM_SRC  = 3;
    localparam int RCA_DEF_NUM_DEST = 2;
    localparam int RCA_DEF_ID_W     = 3;
    localparam int RCA_DEF_SEL_W    = 2;

    // Larger of two sizing values
    function automatic int rca_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Index width for n items, never narrower than one bit
    function automatic int rca_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [RCA_DEF_ID_W-1:0]  id;
        logic [RCA_DEF_SEL_W-1:0] rca_sel;
    } rca_req_t;

    typedef struct packed {
        logic [RCA_DEF_NUM_RCAS*RCA_DEF_NUM_SRC*RCA_REG_ADDR_W-1:0]  src;
        logic [RCA_DEF_NUM_RCAS*RCA_DEF_NUM_DEST*RCA_REG_ADDR_W-1:0] dest;
    } rca_config_t;

endpackage
`default_nettype wire

// File: rtl/rca_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rca_req_fifo
// Summary  : Small synchronous FIFO holding pending execute requests. Depth
//            must be a power of two so the pointers wrap naturally; an extra
//            count bit distinguishes full from empty. Push while full and pop
//            while empty are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module rca_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign pop_data  = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rca_dispatch_unit.sv
`default_nettype none
// ============================================================================
// Module   : rca_dispatch_unit
// Summary  : Owns source/destination register-address configuration for
//            NUM_RCAS accelerators, queues execute requests and dispatches
//            them in order to idle RCAs, and returns one writeback per cycle
//            (config writes first, then the lowest-index finished RCA).
// Options  : RCA_PERF_CNT_EN - adds rca_exec_count, one wrapping 32-bit
//            completion counter per RCA.
// Revision : 1.0 - initial multi-RCA release
// ============================================================================
module rca_dispatch_unit
    import rca_types::*;
#(
    parameter int NUM_RCAS    = 4,
    parameter int NUM_SRC     = 3,
    parameter int NUM_DEST    = 2,
    parameter int QUEUE_DEPTH = 4,
    parameter int ID_W        = 3
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      issue_new_request,
    output logic                                      issue_ready,
    input  logic [ID_W-1:0]                           issue_instruction_id,
    input  logic                                      req_config,
    input  logic [rca_idx_w(NUM_RCAS)-1:0]            req_rca_sel,
    input  logic                                      req_w_src_dest,
    input  logic [rca_idx_w(rca_max(NUM_SRC, NUM_DEST))-1:0] req_w_port_sel,
    input  logic [RCA_REG_ADDR_W-1:0]                 req_w_reg_addr,
    output logic [NUM_RCAS*NUM_SRC*RCA_REG_ADDR_W-1:0]  rca_src_reg_addrs,
    output logic [NUM_RCAS*NUM_DEST*RCA_REG_ADDR_W-1:0] rca_dest_reg_addrs,
    output logic [NUM_RCAS-1:0]                       rca_start,
    output logic [ID_W-1:0]                           rca_start_id,
    input  logic [NUM_RCAS-1:0]                       rca_done,
    output logic                                      wb_done,
    output logic [ID_W-1:0]                           wb_id,
    output logic [31:0]                               wb_rd
`ifdef RCA_PERF_CNT_EN
    ,
    output logic [NUM_RCAS*32-1:0]                    rca_exec_count
`endif
);

    localparam int SEL_W = rca_idx_w(NUM_RCAS);
    localparam int REQ_W = ID_W + SEL_W;
    localparam int N_SRC_REGS  = NUM_RCAS * NUM_SRC;
    localparam int N_DEST_REGS = NUM_RCAS * NUM_DEST;

    // Configuration storage, flattened as [rca][port] with port fastest
    logic [N_SRC_REGS*RCA_REG_ADDR_W-1:0]  r_src_regs;
    logic [N_DEST_REGS*RCA_REG_ADDR_W-1:0] r_dest_regs;
    logic [N_SRC_REGS-1:0]                 w_src_we;
    logic [N_DEST_REGS-1:0]                w_dest_we;

    // Per-RCA tracking
    logic [NUM_RCAS-1:0] r_busy;
    logic [NUM_RCAS-1:0] r_pending;
    logic [ID_W-1:0]     r_busy_id [NUM_RCAS];
    logic                r_cfg_wb;
    logic [ID_W-1:0]     r_cfg_wb_id;

    // Request path
    logic             w_accept;
    logic             w_cfg_accept;
    logic             w_exe_accept;
    logic [REQ_W-1:0] w_fifo_wdata;
    logic [REQ_W-1:0] w_fifo_rdata;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [ID_W-1:0]  w_head_id;
    logic [SEL_W-1:0] w_head_sel;
    logic             w_dispatch;
    logic [NUM_RCAS-1:0] w_start;

    // Writeback arbitration
    logic [NUM_RCAS-1:0] w_grant;
    logic                w_wb_done;
    logic [ID_W-1:0]     w_wb_id;

    assign issue_ready  = !w_fifo_full;
    assign w_accept     = issue_new_request && issue_ready;
    assign w_cfg_accept = w_accept && req_config;
    assign w_exe_accept = w_accept && !req_config;
    assign w_fifo_wdata = {issue_instruction_id, req_rca_sel};
    assign w_head_id    = w_fifo_rdata[REQ_W-1:SEL_W];
    assign w_head_sel   = w_fifo_rdata[SEL_W-1:0];

    rca_req_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (REQ_W)
    ) u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_exe_accept),
        .push_data (w_fifo_wdata),
        .pop       (w_dispatch),
        .pop_data  (w_fifo_rdata),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    // Decode a config write into a one-hot register enable; bad indices write nothing
    always_comb begin
        w_src_we  = '0;
        w_dest_we = '0;
        if (w_cfg_accept && (int'(req_rca_sel) < NUM_RCAS)) begin
            if (!req_w_src_dest) begin
                if (int'(req_w_port_sel) < NUM_SRC) begin
                    w_src_we[int'(req_rca_sel)*NUM_SRC + int'(req_w_port_sel)] = 1'b1;
                end
            end else begin
                if (int'(req_w_port_sel) < NUM_DEST) begin
                    w_dest_we[int'(req_rca_sel)*NUM_DEST + int'(req_w_port_sel)] = 1'b1;
                end
            end
        end
    end

    // Config register file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src_regs  <= '0;
            r_dest_regs <= '0;
        end else begin
            for (int k = 0; k < N_SRC_REGS; k++) begin
                if (w_src_we[k]) begin
                    r_src_regs[k*RCA_REG_ADDR_W +: RCA_REG_ADDR_W] <= req_w_reg_addr;
                end
            end
            for (int k = 0; k < N_DEST_REGS; k++) begin
                if (w_dest_we[k]) begin
                    r_dest_regs[k*RCA_REG_ADDR_W +: RCA_REG_ADDR_W] <= req_w_reg_addr;
                end
            end
        end
    end

    // In-order dispatch: only the FIFO head may start, and only onto an idle RCA
    always_comb begin
        w_start    = '0;
        w_dispatch = !w_fifo_empty && !r_busy[w_head_sel];
        if (w_dispatch) begin
            w_start[w_head_sel] = 1'b1;
        end
    end

    // Writeback arbiter: pending config write wins, then lowest finished RCA
    always_comb begin
        w_grant   = '0;
        w_wb_done = 1'b0;
        w_wb_id   = '0;
        if (r_cfg_wb) begin
            w_wb_done = 1'b1;
            w_wb_id   = r_cfg_wb_id;
        end else begin
            for (int i = 0; i < NUM_RCAS; i++) begin
                if (r_pending[i] && !w_wb_done) begin
                    w_grant[i] = 1'b1;
                    w_wb_done  = 1'b1;
                    w_wb_id    = r_busy_id[i];
                end
            end
        end
    end

    // Config writeback flag: a new config always replaces the one just written back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg_wb    <= 1'b0;
            r_cfg_wb_id <= '0;
        end else begin
            r_cfg_wb <= w_cfg_accept;
            if (w_cfg_accept) begin
                r_cfg_wb_id <= issue_instruction_id;
            end
        end
    end

    // Busy/pending tracking; a done pulse only counts against a busy, not-yet-pending RCA
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy    <= '0;
            r_pending <= '0;
            for (int i = 0; i < NUM_RCAS; i++) begin
                r_busy_id[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RCAS; i++) begin
                if (w_start[i]) begin
                    r_busy[i]    <= 1'b1;
                    r_busy_id[i] <= w_head_id;
                end else if (w_grant[i]) begin
                    r_busy[i]    <= 1'b0;
                end
                if (w_grant[i]) begin
                    r_pending[i] <= 1'b0;
                end else if (rca_done[i] && r_busy[i]) begin
                    r_pending[i] <= 1'b1;
                end
            end
        end
    end

    assign rca_src_reg_addrs  = r_src_regs;
    assign rca_dest_reg_addrs = r_dest_regs;
    assign rca_start          = w_start;
    assign rca_start_id       = w_dispatch ? w_head_id : '0;
    assign wb_done            = w_wb_done;
    assign wb_id              = w_wb_id;
    assign wb_rd              = '0;

`ifdef RCA_PERF_CNT_EN
    generate
        for (genvar g = 0; g < NUM_RCAS; g++) begin : g_perf_cnt
            logic [31:0] r_exec_cnt;

            // Count RCA writebacks, wrapping at 2^32
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_exec_cnt <= '0;
                end else if (w_grant[g]) begin
                    r_exec_cnt <= r_exec_cnt + 32'd1;
                end
            end

            assign rca_exec_count[g*32 +: 32] = r_exec_cnt;
        end
    endgenerate
`else
    // Completion counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_rca_dispatch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rca_dispatch_unit
// Summary  : Scoreboard bench for rca_dispatch_unit. A queue-based reference
//            model predicts start pulses, writebacks and config contents; a
//            monitor pops predictions whenever the DUT presents them.
//            Honours RCA_PERF_CNT_EN when the design is built with it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rca_dispatch_unit;
    import rca_types::*;

    localparam int NUM_RCAS    = 4;
    localparam int NUM_SRC     = 3;
    localparam int NUM_DEST    = 2;
    localparam int QUEUE_DEPTH = 4;
    localparam int ID_W        = 3;
    localparam int SRC_W       = NUM_RCAS*NUM_SRC*5;
    localparam int DEST_W      = NUM_RCAS*NUM_DEST*5;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                issue_new_request = 1'b0;
    logic                issue_ready;
    logic [ID_W-1:0]     issue_instruction_id = '0;
    logic                req_config = 1'b0;
    logic [1:0]          req_rca_sel = '0;
    logic                req_w_src_dest = 1'b0;
    logic [1:0]          req_w_port_sel = '0;
    logic [4:0]          req_w_reg_addr = '0;
    logic [SRC_W-1:0]    rca_src_reg_addrs;
    logic [DEST_W-1:0]   rca_dest_reg_addrs;
    logic [NUM_RCAS-1:0] rca_start;
    logic [ID_W-1:0]     rca_start_id;
    logic [NUM_RCAS-1:0] rca_done = '0;
    logic                wb_done;
    logic [ID_W-1:0]     wb_id;
    logic [31:0]         wb_rd;
`ifdef RCA_PERF_CNT_EN
    logic [NUM_RCAS*32-1:0] rca_exec_count;
`endif

    always #5 clk = ~clk;

    rca_dispatch_unit #(
        .NUM_RCAS(NUM_RCAS), .NUM_SRC(NUM_SRC), .NUM_DEST(NUM_DEST),
        .QUEUE_DEPTH(QUEUE_DEPTH), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_new_request(issue_new_request), .issue_ready(issue_ready),
        .issue_instruction_id(issue_instruction_id), .req_config(req_config),
        .req_rca_sel(req_rca_sel), .req_w_src_dest(req_w_src_dest),
        .req_w_port_sel(req_w_port_sel), .req_w_reg_addr(req_w_reg_addr),
        .rca_src_reg_addrs(rca_src_reg_addrs), .rca_dest_reg_addrs(rca_dest_reg_addrs),
        .rca_start(rca_start), .rca_start_id(rca_start_id), .rca_done(rca_done),
        .wb_done(wb_done), .wb_id(wb_id), .wb_rd(wb_rd)
`ifdef RCA_PERF_CNT_EN
        , .rca_exec_count(rca_exec_count)
`endif
    );

    typedef struct { int cyc; logic [ID_W-1:0] id; } wb_exp_t;
    typedef struct { int cyc; int sel; logic [ID_W-1:0] id; } st_exp_t;
    typedef struct {
        int                     cyc;
        bit                     in_rst;
        bit                     ready;
        logic [SRC_W-1:0]       src;
        logic [DEST_W-1:0]      dest;
        logic [NUM_RCAS*32-1:0] cnt;
    } cyc_exp_t;

    wb_exp_t  q_wb[$];
    st_exp_t  q_st[$];
    cyc_exp_t q_cyc[$];

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    // Reference model state
    int              m_src [NUM_RCAS][NUM_SRC];
    int              m_dest[NUM_RCAS][NUM_DEST];
    rca_req_t        m_q[$];
    bit              m_busy[NUM_RCAS];
    bit              m_pend[NUM_RCAS];
    logic [ID_W-1:0] m_busy_id[NUM_RCAS];
    bit              m_cfg_wb;
    logic [ID_W-1:0] m_cfg_id;
    int              m_cnt[NUM_RCAS];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cycle);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NUM_RCAS; r++) begin
            for (int p = 0; p < NUM_SRC; p++)  m_src[r][p]  = 0;
            for (int p = 0; p < NUM_DEST; p++) m_dest[r][p] = 0;
            m_busy[r] = 0; m_pend[r] = 0; m_busy_id[r] = '0; m_cnt[r] = 0;
        end
        m_q.delete();
        m_cfg_wb = 0;
        m_cfg_id = '0;
    endtask

    function automatic bit model_idle();
        bit idle = (m_q.size() == 0) && !m_cfg_wb;
        for (int r = 0; r < NUM_RCAS; r++) if (m_busy[r] || m_pend[r]) idle = 0;
        return idle;
    endfunction

    // One clock cycle: drive inputs, predict this cycle's outputs, advance model
    task automatic step(input bit r, input bit req, input bit cfg, input int sel, input bit sd,
                        input int port, input int addr, input int id, input logic [NUM_RCAS-1:0] done);
        cyc_exp_t ce;
        rca_req_t hd;
        bit       ready, accept, disp;
        int       gnt;
        @(negedge clk);
        cycle++;
        rst = r; issue_new_request = req; req_config = cfg;
        req_rca_sel = sel[1:0]; req_w_src_dest = sd; req_w_port_sel = port[1:0];
        req_w_reg_addr = addr[4:0]; issue_instruction_id = id[ID_W-1:0]; rca_done = done;
        if (r) model_reset();
        ready = (m_q.size() < QUEUE_DEPTH);
        if (!r) begin
            disp = (m_q.size() > 0) && !m_busy[m_q[0].rca_sel];
            if (disp) q_st.push_back('{cycle, int'(m_q[0].rca_sel), m_q[0].id});
            gnt = -1;
            if (m_cfg_wb) begin
                q_wb.push_back('{cycle, m_cfg_id});
            end else begin
                for (int i = 0; i < NUM_RCAS; i++) begin
                    if (m_pend[i] && gnt < 0) gnt = i;
                end
                if (gnt >= 0) q_wb.push_back('{cycle, m_busy_id[gnt]});
            end
        end
        ce.cyc = cycle; ce.in_rst = r; ce.ready = ready; ce.src = '0; ce.dest = '0; ce.cnt = '0;
        for (int a = 0; a < NUM_RCAS; a++) begin
            for (int p = 0; p < NUM_SRC; p++)  ce.src[(a*NUM_SRC+p)*5 +: 5]  = 5'(m_src[a][p]);
            for (int p = 0; p < NUM_DEST; p++) ce.dest[(a*NUM_DEST+p)*5 +: 5] = 5'(m_dest[a][p]);
            ce.cnt[a*32 +: 32] = 32'(m_cnt[a]);
        end
        q_cyc.push_back(ce);
        if (!r) begin
            for (int i = 0; i < NUM_RCAS; i++) begin
                if (i == gnt) begin
                    m_pend[i] = 0; m_busy[i] = 0; m_cnt[i]++;
                end else if (done[i] && m_busy[i]) begin
                    m_pend[i] = 1;
                end
            end
            if (disp) begin
                hd = m_q.pop_front();
                m_busy[hd.rca_sel] = 1;
                m_busy_id[hd.rca_sel] = hd.id;
            end
            accept   = req && ready;
            m_cfg_wb = accept && cfg;
            if (accept && cfg) begin
                m_cfg_id = id[ID_W-1:0];
                if (!sd && port < NUM_SRC)  m_src[sel][port]  = addr;
                if (sd && port < NUM_DEST)  m_dest[sel][port] = addr;
            end
            if (accept && !cfg) begin
                hd.id = id[ID_W-1:0]; hd.rca_sel = sel[1:0];
                m_q.push_back(hd);
            end
        end
    endtask

    task automatic idle(input int n, input logic [NUM_RCAS-1:0] done);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, (k == 0) ? done : '0);
    endtask

    task automatic exe(input int sel, input int id);
        step(0, 1, 0, sel, 0, 0, 0, id, '0);
    endtask

    // Complete every busy RCA until the model has nothing left in flight
    task automatic drain();
        logic [NUM_RCAS-1:0] d;
        for (int n = 0; n < 300 && !model_idle(); n++) begin
            d = '0;
            for (int i = 0; i < NUM_RCAS; i++) d[i] = m_busy[i] && ($urandom_range(1) == 1);
            step(0, 0, 0, 0, 0, 0, 0, 0, d);
        end
        idle(3, '0);
    endtask

    // Monitor: compare per-cycle state, pop events as the DUT presents them
    initial begin
        cyc_exp_t ce;
        wb_exp_t  we;
        st_exp_t  se;
        logic [NUM_RCAS-1:0] oh;
        forever begin
            @(negedge clk);
            #2;
            if (q_cyc.size() != 0) begin
                ce = q_cyc.pop_front();
                if (!ce.in_rst) check("issue_ready", issue_ready, ce.ready);
                check("src_regs", rca_src_reg_addrs, ce.src);
                check("dest_regs", rca_dest_reg_addrs, ce.dest);
                check("wb_rd", wb_rd, '0);
`ifdef RCA_PERF_CNT_EN
                check("exec_count", rca_exec_count, ce.cnt);
`endif
                if (ce.in_rst) check("rst_wb_id", wb_id, '0);
                if (wb_done) begin
                    if (q_wb.size() == 0) begin
                        check("wb_spurious", 1'b1, 1'b0);
                    end else begin
                        we = q_wb.pop_front();
                        check("wb_cycle", cycle, we.cyc);
                        check("wb_id", wb_id, we.id);
                    end
                end else if (q_wb.size() != 0 && q_wb[0].cyc <= cycle) begin
                    we = q_wb.pop_front();
                    check("wb_missing", 1'b0, 1'b1);
                end
                if (|rca_start) begin
                    if (q_st.size() == 0) begin
                        check("start_spurious", rca_start, '0);
                    end else begin
                        se = q_st.pop_front();
                        oh = '0; oh[se.sel] = 1'b1;
                        check("start_cycle", cycle, se.cyc);
                        check("start_vec", rca_start, oh);
                        check("start_id", rca_start_id, se.id);
                    end
                end else if (q_st.size() != 0 && q_st[0].cyc <= cycle) begin
                    se = q_st.pop_front();
                    check("start_missing", 1'b0, 1'b1);
                end
            end
        end
    end

    initial begin
        logic [NUM_RCAS-1:0] d;
        model_reset();
        // Reset state
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 0, 0, 0, '0);
        idle(2, '0);

        // Config write RCA2 dest port 1 = 17, id 5; then out-of-range port
        step(0, 1, 1, 2, 1, 1, 17, 5, '0);
        step(0, 1, 1, 1, 1, 3, 9, 6, '0);
        step(0, 1, 1, 0, 0, 2, 23, 7, '0);
        idle(2, '0);

        // Two executes to RCA0 back to back; second waits for first writeback
        exe(0, 1);
        exe(0, 2);
        idle(3, '0);
        idle(3, 4'b0001);
        idle(3, 4'b0001);
        idle(3, 4'b0001);
        drain();

        // Fill the FIFO behind a busy RCA1
        exe(1, 3);
        idle(2, '0);
        for (int k = 0; k < 4; k++) exe(1, 4 + k);
        exe(1, 0);
        idle(2, '0);
        idle(3, 4'b0010);
        drain();

        // Simultaneous completions on RCA1 and RCA3 with a config accept
        exe(1, 1);
        exe(3, 3);
        idle(2, '0);
        step(0, 1, 1, 3, 0, 0, 11, 6, 4'b1010);
        idle(4, '0);
        drain();

        // Randomised traffic
        for (int n = 0; n < 1500; n++) begin
            d = '0;
            for (int i = 0; i < NUM_RCAS; i++)
                d[i] = m_busy[i] ? ($urandom_range(9) < 3) : ($urandom_range(19) == 0);
            if ((m_q.size() < QUEUE_DEPTH) && ($urandom_range(9) < 6))
                step(0, 1, $urandom_range(9) < 3, $urandom_range(3), $urandom_range(1),
                     $urandom_range(3), $urandom_range(31), $urandom_range(7), d);
            else
                step(0, 0, 0, 0, 0, 0, 0, 0, d);
        end
        drain();

        // Reset with two RCAs in flight; later done pulses must be ignored
        exe(0, 2);
        exe(2, 4);
        step(0, 1, 1, 1, 0, 1, 30, 1, '0);
        idle(2, '0);
        step(1, 0, 0, 0, 0, 0, 0, 0, '0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 4'b0101);
        idle(1, '0);
        idle(4, 4'b0101);

        @(negedge clk);
        #5;
        check("wb_queue_drained", q_wb.size(), 0);
        check("start_queue_drained", q_st.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
